// File: rtl/qft_state_loader.sv
// Serial-to-parallel loader for the 3-qubit QFT datapath: gathers 8 complex
// amplitudes from a valid/ready stream and presents them as one frame.
module qft_state_loader #(
    parameter int DATA_W      = 16,
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data_r,
    input  logic signed [DATA_W-1:0] s_data_i,
    input  logic                     s_last,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic signed [DATA_W-1:0] out_000_r,
    output logic signed [DATA_W-1:0] out_000_i,
    output logic signed [DATA_W-1:0] out_001_r,
    output logic signed [DATA_W-1:0] out_001_i,
    output logic signed [DATA_W-1:0] out_010_r,
    output logic signed [DATA_W-1:0] out_010_i,
    output logic signed [DATA_W-1:0] out_011_r,
    output logic signed [DATA_W-1:0] out_011_i,
    output logic signed [DATA_W-1:0] out_100_r,
    output logic signed [DATA_W-1:0] out_100_i,
    output logic signed [DATA_W-1:0] out_101_r,
    output logic signed [DATA_W-1:0] out_101_i,
    output logic signed [DATA_W-1:0] out_110_r,
    output logic signed [DATA_W-1:0] out_110_i,
    output logic signed [DATA_W-1:0] out_111_r,
    output logic signed [DATA_W-1:0] out_111_i,
    output logic                     err,
    input  logic                     err_clr,
    output logic [7:0]               frames_done
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [2:0]              wr_slot;
    logic                    s_ready_q, s_ready_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    err_q, err_d;
    logic [7:0]              frames_done_q, frames_done_d;
    logic [7:0][DATA_W-1:0]  slot_r_q, slot_r_d;
    logic [7:0][DATA_W-1:0]  slot_i_q, slot_i_d;
    logic                    accept;

    // s_ready_q is only ever high in FILL, so it alone qualifies acceptance.
    assign accept  = s_valid && s_ready_q;
    assign wr_slot = BIT_REVERSE ? {idx_q[0], idx_q[1], idx_q[2]} : idx_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        err_d         = err_q;
        frames_done_d = frames_done_q;
        slot_r_d      = slot_r_q;
        slot_i_d      = slot_i_q;
        if (err_clr) err_d = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    slot_r_d[wr_slot] = s_data_r;
                    slot_i_d[wr_slot] = s_data_i;
                    if (s_last && idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = HOLD;
                    end else if (s_last || idx_q == 3'd7) begin
                        // Misframed beat: consume it, drop the partial frame, set wins over clear.
                        err_d = 1'b1;
                        idx_d = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    state_d       = FILL;
                    frames_done_d = frames_done_q + 8'd1;
                end
            end
            default: state_d = FILL;
        endcase
        s_ready_d     = (state_d == FILL);
        frame_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            idx_q         <= 3'd0;
            s_ready_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
            frames_done_q <= 8'd0;
            slot_r_q      <= '0;
            slot_i_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            s_ready_q     <= s_ready_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
            frames_done_q <= frames_done_d;
            slot_r_q      <= slot_r_d;
            slot_i_q      <= slot_i_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign frame_valid = frame_valid_q;
    assign err         = err_q;
    assign frames_done = frames_done_q;

    assign out_000_r = slot_r_q[0];
    assign out_000_i = slot_i_q[0];
    assign out_001_r = slot_r_q[1];
    assign out_001_i = slot_i_q[1];
    assign out_010_r = slot_r_q[2];
    assign out_010_i = slot_i_q[2];
    assign out_011_r = slot_r_q[3];
    assign out_011_i = slot_i_q[3];
    assign out_100_r = slot_r_q[4];
    assign out_100_i = slot_i_q[4];
    assign out_101_r = slot_r_q[5];
    assign out_101_i = slot_i_q[5];
    assign out_110_r = slot_r_q[6];
    assign out_110_i = slot_i_q[6];
    assign out_111_r = slot_r_q[7];
    assign out_111_i = slot_i_q[7];

endmodule

// File: tb/tb_qft_state_loader.sv
// Bench for qft_state_loader: a natural-order and a bit-reversed instance share
// one stimulus stream and are checked against a slot-mapping reference model.
module tb_qft_state_loader;

    logic clk = 1'b0;
    logic rst, s_valid, s_last, frame_ready, err_clr;
    logic [15:0] s_data_r, s_data_i;
    logic s_ready0, s_ready1, fv0, fv1, err0, err1;
    logic [7:0] fd0, fd1;
    logic [7:0][15:0] o0r, o0i, o1r, o1i;

    int vectors = 0;
    int miscompares = 0;
    int fd_exp = 0;
    int err_exp = 0;
    logic [15:0] br [8];
    logic [15:0] bi [8];
    // Where beat k lands when the loader reverses the 3-bit index.
    int rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    qft_state_loader #(.DATA_W(16), .BIT_REVERSE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
        .s_data_r(s_data_r), .s_data_i(s_data_i), .s_last(s_last),
        .frame_valid(fv0), .frame_ready(frame_ready),
        .out_000_r(o0r[0]), .out_000_i(o0i[0]), .out_001_r(o0r[1]), .out_001_i(o0i[1]),
        .out_010_r(o0r[2]), .out_010_i(o0i[2]), .out_011_r(o0r[3]), .out_011_i(o0i[3]),
        .out_100_r(o0r[4]), .out_100_i(o0i[4]), .out_101_r(o0r[5]), .out_101_i(o0i[5]),
        .out_110_r(o0r[6]), .out_110_i(o0i[6]), .out_111_r(o0r[7]), .out_111_i(o0i[7]),
        .err(err0), .err_clr(err_clr), .frames_done(fd0)
    );

    qft_state_loader #(.DATA_W(16), .BIT_REVERSE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1),
        .s_data_r(s_data_r), .s_data_i(s_data_i), .s_last(s_last),
        .frame_valid(fv1), .frame_ready(frame_ready),
        .out_000_r(o1r[0]), .out_000_i(o1i[0]), .out_001_r(o1r[1]), .out_001_i(o1i[1]),
        .out_010_r(o1r[2]), .out_010_i(o1i[2]), .out_011_r(o1r[3]), .out_011_i(o1i[3]),
        .out_100_r(o1r[4]), .out_100_i(o1i[4]), .out_101_r(o1r[5]), .out_101_i(o1i[5]),
        .out_110_r(o1r[6]), .out_110_i(o1i[6]), .out_111_r(o1r[7]), .out_111_i(o1i[7]),
        .err(err1), .err_clr(err_clr), .frames_done(fd1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat; returns at the negedge after the accepting posedge.
    task automatic beat(input logic [15:0] r, input logic [15:0] i, input logic last, input int gap);
        int n = 0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid  = 1'b1;
        s_data_r = r;
        s_data_i = i;
        s_last   = last;
        while (!s_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("ready_timeout", {31'd0, s_ready0}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input int gapmax);
        for (int k = 0; k < 8; k++)
            beat(br[k], bi[k], k == 7, (gapmax == 0) ? 0 : $urandom_range(gapmax, 0));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic rand_frame_data();
        for (int k = 0; k < 8; k++) begin
            br[k] = 16'($urandom);
            bi[k] = 16'($urandom);
        end
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_fv0"}, {31'd0, fv0}, 32'd1);
        chk({tag, "_fv1"}, {31'd0, fv1}, 32'd1);
        chk({tag, "_rdy_hold"}, {31'd0, s_ready0}, 32'd0);
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("%s_n%0d_r", tag, s), {16'd0, o0r[s]}, {16'd0, br[s]});
            chk($sformatf("%s_n%0d_i", tag, s), {16'd0, o0i[s]}, {16'd0, bi[s]});
            chk($sformatf("%s_b%0d_r", tag, s), {16'd0, o1r[s]}, {16'd0, br[rev_tab[s]]});
            chk($sformatf("%s_b%0d_i", tag, s), {16'd0, o1i[s]}, {16'd0, bi[rev_tab[s]]});
        end
    endtask

    task automatic handoff(input string tag, input int wait_cyc);
        repeat (wait_cyc) @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        fd_exp = (fd_exp + 1) % 256;
        chk({tag, "_fd0"}, {24'd0, fd0}, fd_exp);
        chk({tag, "_fd1"}, {24'd0, fd1}, fd_exp);
        chk({tag, "_fv_low"}, {31'd0, fv0}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, s_ready0 & s_ready1}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; frame_ready = 1'b0; err_clr = 1'b0;
        s_data_r = '0; s_data_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", {31'd0, s_ready0}, 32'd0);
        chk("rst_fv", {31'd0, fv0 | fv1}, 32'd0);
        chk("rst_err", {31'd0, err0 | err1}, 32'd0);
        chk("rst_fd", {24'd0, fd0}, 32'd0);
        chk("rst_out", {16'd0, o0r[3] | o1i[7]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", {31'd0, s_ready0}, 32'd1);

        // Natural and reversed load of r=k*256, i=-k back to back.
        for (int k = 0; k < 8; k++) begin
            br[k] = 16'(k * 256);
            bi[k] = 16'(-k);
        end
        for (int k = 0; k < 7; k++) beat(br[k], bi[k], 1'b0, 0);
        chk("fv_before_last", {31'd0, fv0}, 32'd0);
        beat(br[7], bi[7], 1'b1, 0);
        s_valid = 1'b0; s_last = 1'b0;
        check_frame("nat");
        chk("out011_r", {16'd0, o0r[3]}, 32'd768);
        chk("out011_i", {16'd0, o0i[3]}, 32'h0000_fffd);
        chk("rev100_r", {16'd0, o1r[4]}, 32'd256);
        chk("rev011_r", {16'd0, o1r[3]}, 32'd1536);

        // Backpressure: HOLD with s_valid asserted must accept nothing.
        s_valid = 1'b1; s_data_r = 16'h7fff; s_data_i = 16'h8000; s_last = 1'b1;
        repeat (20) @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        check_frame("bp");
        handoff("bp", 0);
        rand_frame_data();
        send_frame(0);
        check_frame("after_bp");
        handoff("after_bp", 2);

        // Early s_last on beat 4.
        for (int k = 0; k < 5; k++) beat(16'(k), 16'(k), k == 4, 0);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("err_early", {31'd0, err0 & err1}, 32'd1);
        chk("err_early_fv", {31'd0, fv0 | fv1}, 32'd0);
        rand_frame_data();
        send_frame(0);
        check_frame("after_err");
        chk("err_sticky", {31'd0, err0}, 32'd1);
        handoff("after_err", 0);

        // Missing s_last on beat 7.
        for (int k = 0; k < 8; k++) beat(16'(k), 16'(k), 1'b0, 0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("err_missing", {31'd0, err0}, 32'd1);
        chk("err_missing_fv", {31'd0, fv0}, 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", {31'd0, err0 | err1}, 32'd0);

        // Clear and new error in the same cycle: set wins.
        err_clr = 1'b1;
        beat(16'd1, 16'd1, 1'b1, 0);
        err_clr = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        chk("err_set_wins", {31'd0, err0}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr2", {31'd0, err0}, 32'd0);

        // Reset after 5 beats discards the partial frame.
        for (int k = 0; k < 5; k++) beat(16'(100 + k), 16'(k), 1'b0, 0);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", {31'd0, s_ready0}, 32'd0);
        chk("mrst_fv", {31'd0, fv0}, 32'd0);
        chk("mrst_fd", {24'd0, fd0}, 32'd0);
        chk("mrst_out", {16'd0, o0r[0] | o0r[4] | o1r[2] | o1i[1]}, 32'd0);
        rst = 1'b0;
        fd_exp = 0;
        @(negedge clk);
        rand_frame_data();
        send_frame(0);
        check_frame("after_mrst");
        handoff("after_mrst", 1);

        // Random bubbles; 255 more handoffs bring frames_done from 1 to 0.
        for (int f = 0; f < 255; f++) begin
            rand_frame_data();
            send_frame(3);
            check_frame($sformatf("rnd%0d", f));
            handoff($sformatf("rnd%0d", f), $urandom_range(2, 0));
        end
        chk("fd_wrap", {24'd0, fd0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qft_state_loader.md
Name: qft_state_loader

Overview:
- Stream-to-parallel loader at the input of the pipelined 3-qubit QFT datapath.
- Accepts 8 complex fixed-point amplitudes serially over a valid/ready stream, assembles a full state vector, and presents it in parallel with a frame handshake.
- Optionally applies the 3-bit index bit-reversal on load. The output-side swap stage can then be bypassed for natural-order results, or kept for a double-reversed (identity) check.

Parameters:
- DATA_W, default `TOTAL_WIDTH (fixed_point_params.vh, 16): width of each signed real/imag component.
- BIT_REVERSE, default 0: 0 = beat k lands in slot k; 1 = beat k lands in slot bitrev3(k) (1<->4, 3<->6; 0, 2, 5, 7 fixed).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- s_valid  input  1  input beat valid.
- s_ready  output  1  loader can accept a beat.
- s_data_r  input  DATA_W  signed real part of amplitude.
- s_data_i  input  DATA_W  signed imag part of amplitude.
- s_last  input  1  marks beat 7 of a frame.
- frame_valid  output  1  parallel vector is valid.
- frame_ready  input  1  downstream pipeline accepts vector.
- out_<k>_r / out_<k>_i, k = 000..111  output  DATA_W each (16 buses)  assembled amplitude for basis state k.
- err  output  1  sticky framing error.
- err_clr  input  1  clears err.
- frames_done  output  8  count of frames handed off; wraps 255->0.

Behaviour:
- Clock and reset: all state updates on posedge clk.
- Reset values: rst=1 forces state FILL, beat index 0, all 16 slot registers 0, frame_valid 0, s_ready 0 during the reset cycle, err 0, frames_done 0.
- Reset mid-frame discards partial data; the first beat after reset is beat 0.
- FSM states: FILL and HOLD.
- FILL:
  - s_ready=1 (registered; asserted the cycle after rst deasserts).
  - A beat is accepted when s_valid && s_ready.
  - Accepted data is written to slot idx (BIT_REVERSE=0) or bitrev3(idx) (BIT_REVERSE=1); idx increments.
  - On an accepted beat with idx==7 and s_last=1: idx->0, go to HOLD.
  - frame_valid=1 starting the cycle after the 8th beat. Beat-to-frame latency is 1 cycle.
- HOLD:
  - s_ready=0, frame_valid=1.
  - out_* held stable until handoff.
  - On frame_ready=1: frame_valid->0, frames_done+1, return to FILL; s_ready=1 the next cycle.
  - frame_ready while in FILL is ignored.
  - Minimum frame period is 9 cycles (8 beats + 1 handoff cycle).
- Framing error:
  - Triggered by an accepted beat with s_last=1 and idx!=7, or s_last=0 and idx==7.
  - Response: err<=1, idx<=0, stay in FILL, partial frame discarded.
  - Slot registers are not cleared; stale values are never exposed because frame_valid stays 0.
  - The erroring beat itself is consumed.
- err clearing:
  - err stays set until err_clr=1.
  - If err_clr and a new error occur in the same cycle, err stays 1 (set wins).
- Output registers:
  - out_* change only on accepted beats in FILL.
  - Slots from the previous frame remain visible while the next frame fills; frame_valid qualifies them.
- Arithmetic: none. Data is passed bit-exact, no saturation or rounding.
- Input rules: s_valid may toggle freely; data is sampled only on acceptance. Bubbles between beats are allowed with no timeout.

Test Plan:
- Natural load (BIT_REVERSE=0): send r=k*256, i=-k for k=0..7 back-to-back with s_last on k=7 -> frame_valid rises exactly 1 cycle after the 8th beat; out_011_r=768, out_011_i=-3; s_ready=0 in HOLD.
- Reversed load (BIT_REVERSE=1): same stream -> out_100_r=256, out_001_r=1024, out_110_r=768, out_011_r=1536, out_010_r=512; frames_done increments by 1 on frame_ready.
- Backpressure: hold frame_ready=0 for 20 cycles while s_valid=1 -> out_* stable, no beats accepted; pulse frame_ready -> s_ready=1 the next cycle, next frame loads correctly.
- Framing errors: s_last on beat 4 -> err=1, no frame_valid; the following clean 8-beat frame is delivered. Then omit s_last on beat 7 -> err stays 1. Assert err_clr -> err=0 the next cycle.
- Reset mid-frame: rst after 5 beats -> all outputs 0, frame_valid 0; a subsequent full frame is assembled from beat 0.
- Bubbles and wrap: random s_valid gaps across 256 frames -> each frame is correct; frames_done wraps to 0 after 256.
